// File: rtl/seg7_page_display.sv
// Paged multi-channel hex display: channel/page cursor, auto-cycle tick, hold snapshot, leading-zero blanking.
// Define SEG7_HOLD_BLINK_EN to blink the display while HOLD is asserted.
module seg7_page_display #(
    parameter int NUM_DIGITS = 6,
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int TICK_DIV   = 50000000,
    parameter int BLINK_DIV  = 12500000,
    localparam int NPAGE     = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS),
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PG_W      = (NPAGE > 1) ? $clog2(NPAGE) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
    input  logic                     NEXT_PAGE,
    input  logic                     AUTO,
    input  logic                     HOLD,
    input  logic                     BLANK_LZ,
    output logic [NUM_DIGITS*8-1:0]  nHEX,
    output logic [CH_W-1:0]          CH_SEL,
    output logic [PG_W-1:0]          PAGE
);
    localparam int NNIB = DATA_W / 4;
    localparam int TW   = $clog2(TICK_DIV);

    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [CH_W-1:0]         ch_sel_q, ch_sel_d;
    logic [PG_W-1:0]         page_q, page_d;
    logic [DATA_W-1:0]       snap_q, snap_d;
    logic                    load_pend_q, load_pend_d;
    logic [NUM_DIGITS*8-1:0] hex_q, hex_d;
    logic                    tick, advance;
    logic [DATA_W-1:0]       ch_word;

    function automatic logic [7:0] hex2seg(input logic [3:0] v);
        case (v)
            4'h0: hex2seg = 8'hC0; 4'h1: hex2seg = 8'hF9; 4'h2: hex2seg = 8'hA4; 4'h3: hex2seg = 8'hB0;
            4'h4: hex2seg = 8'h99; 4'h5: hex2seg = 8'h92; 4'h6: hex2seg = 8'h82; 4'h7: hex2seg = 8'hF8;
            4'h8: hex2seg = 8'h80; 4'h9: hex2seg = 8'h90; 4'hA: hex2seg = 8'h88; 4'hB: hex2seg = 8'h83;
            4'hC: hex2seg = 8'hC6; 4'hD: hex2seg = 8'hA1; 4'hE: hex2seg = 8'h86; default: hex2seg = 8'h8E;
        endcase
    endfunction

    always_comb begin
        ch_word = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (CH_W'(i) == ch_sel_q) ch_word = CH_DATA[i*DATA_W +: DATA_W];
    end

    always_comb begin
        tick    = AUTO && (tick_cnt_q == TW'(TICK_DIV - 1));
        advance = NEXT_PAGE || tick;

        // A manual advance also restarts the period so the next auto step is a full period away.
        if (!AUTO || advance) tick_cnt_d = '0;
        else                  tick_cnt_d = tick_cnt_q + TW'(1);

        ch_sel_d = ch_sel_q;
        page_d   = page_q;
        if (advance) begin
            if (page_q == PG_W'(NPAGE - 1)) begin
                page_d   = '0;
                ch_sel_d = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);
            end else begin
                page_d = page_q + PG_W'(1);
            end
        end

        // The load under HOLD uses the already-updated channel, one cycle after the cursor moves.
        load_pend_d = advance;
        snap_d      = (!HOLD || load_pend_q) ? ch_word : snap_q;
    end

`ifdef SEG7_HOLD_BLINK_EN
    localparam int BW = $clog2(2*BLINK_DIV);
    logic [BW-1:0] blink_q, blink_d;
    logic          blink_off;

    always_comb begin
        if (!HOLD || blink_q == BW'(2*BLINK_DIV - 1)) blink_d = '0;
        else                                          blink_d = blink_q + BW'(1);
        blink_off = (blink_q >= BW'(BLINK_DIV));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) blink_q <= '0;
        else      blink_q <= blink_d;
    end
`endif

    always_comb begin
        int unsigned top;
        int unsigned n;
        logic [7:0]  seg;
        top   = 0;
        hex_d = '1;
        for (int unsigned i = 0; i < NNIB; i++)
            if (snap_q[i*4 +: 4] != 4'h0) top = i;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            n = 32'(page_q) * NUM_DIGITS + d;
            if (n >= NNIB)             seg = 8'hFF;
            else if (BLANK_LZ && n > top) seg = 8'hFF;
            else                       seg = hex2seg(snap_q[n*4 +: 4]);
            if (d == 0 && page_q != '0) seg[7] = 1'b0;
            hex_d[d*8 +: 8] = seg;
        end
`ifdef SEG7_HOLD_BLINK_EN
        if (blink_off) hex_d = '1;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_cnt_q  <= '0;
            ch_sel_q    <= '0;
            page_q      <= '0;
            snap_q      <= '0;
            load_pend_q <= 1'b0;
            hex_q       <= '1;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            ch_sel_q    <= ch_sel_d;
            page_q      <= page_d;
            snap_q      <= snap_d;
            load_pend_q <= load_pend_d;
            hex_q       <= hex_d;
        end
    end

    assign nHEX   = hex_q;
    assign CH_SEL = ch_sel_q;
    assign PAGE   = page_q;

endmodule

// File: tb/tb_seg7_page_display.sv
// Self-checking bench for seg7_page_display: directed scenarios plus randomized stimulus against a cycle model.
module tb_seg7_page_display;
    localparam int ND   = 6;
    localparam int NCH  = 4;
    localparam int DW   = 32;
    localparam int TD   = 8;
    localparam int NPG  = 2;
    localparam int NNIB = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NCH*DW-1:0] CH_DATA;
    logic              NEXT_PAGE = 1'b0, AUTO = 1'b0, HOLD = 1'b0, BLANK_LZ = 1'b0;
    logic [ND*8-1:0]   nHEX;
    logic [1:0]        CH_SEL;
    logic [0:0]        PAGE;

    logic [31:0] ch [NCH];

    seg7_page_display #(
        .NUM_DIGITS(ND), .NUM_CH(NCH), .DATA_W(DW), .TICK_DIV(TD), .BLINK_DIV(4)
    ) dut (
        .CLK(CLK), .RST(RST), .CH_DATA(CH_DATA), .NEXT_PAGE(NEXT_PAGE), .AUTO(AUTO),
        .HOLD(HOLD), .BLANK_LZ(BLANK_LZ), .nHEX(nHEX), .CH_SEL(CH_SEL), .PAGE(PAGE)
    );

    always #5 CLK = ~CLK;

    always_comb
        for (int i = 0; i < NCH; i++) CH_DATA[i*DW +: DW] = ch[i];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: linear cursor position, cycles into the current auto period, snapshot, pending load.
    int          m_pos = 0;
    int          m_cnt = 0;
    logic [63:0] m_snap = '0;
    bit          m_pend = 1'b0;
    logic [47:0] m_hex = '1;

    logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] exp_disp(input logic [63:0] snap, input int page, input bit blz);
        logic [47:0] r;
        logic [7:0]  s;
        int          n;
        for (int d = 0; d < ND; d++) begin
            n = page * ND + d;
            if (n >= NNIB)                             s = 8'hFF;
            else if (blz && n != 0 && (snap >> (4*n)) == 0) s = 8'hFF;
            else                                       s = lut[(snap >> (4*n)) & 64'hF];
            if (d == 0 && page != 0) s = s & 8'h7F;
            r[d*8 +: 8] = s;
        end
        return r;
    endfunction

    task automatic step();
        int          ch_now = m_pos / NPG;
        bit          tick   = AUTO && (m_cnt == TD - 1);
        bit          adv    = NEXT_PAGE || tick;
        logic [47:0] nh     = exp_disp(m_snap, m_pos % NPG, BLANK_LZ);
        logic [63:0] ns     = (!HOLD || m_pend) ? {32'b0, ch[ch_now]} : m_snap;
        @(posedge CLK); #1;
        m_hex  = nh;
        m_snap = ns;
        m_pend = adv;
        m_cnt  = (AUTO && !adv) ? m_cnt + 1 : 0;
        if (adv) m_pos = (m_pos + 1) % (NCH * NPG);
        check("nhex", nHEX, m_hex);
        check("ch_sel", CH_SEL, m_pos / NPG);
        check("page", PAGE, m_pos % NPG);
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic pulse();
        NEXT_PAGE = 1'b1;
        step();
        NEXT_PAGE = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        check("rst_nhex", nHEX, 48'hFFFF_FFFF_FFFF);
        check("rst_ch_sel", CH_SEL, 0);
        check("rst_page", PAGE, 0);
        m_pos = 0; m_cnt = 0; m_snap = '0; m_pend = 1'b0; m_hex = '1;
        @(posedge CLK); #1;
        RST = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) ch[i] = '0;
        @(posedge CLK); #1;
        do_reset();

        ch[0] = 32'h0000_00A5;
        steps(2);
        check("tp_a5", nHEX, 48'hC0C0_C0C0_8892);
        BLANK_LZ = 1'b1;
        step();
        check("tp_a5_lz", nHEX, 48'hFFFF_FFFF_8892);
        ch[0] = 32'h0;
        steps(2);
        check("tp_zero_lz", nHEX, 48'hFFFF_FFFF_FFC0);

        ch[1] = 32'hDEAD_BEEF;
        pulse(); steps(2);
        check("tp_pg1", {CH_SEL, PAGE}, {2'd0, 1'b1});
        pulse(); steps(2);
        check("tp_ch1pg0", {CH_SEL, PAGE}, {2'd1, 1'b0});
        pulse(); steps(2);
        check("tp_ch1pg1", {CH_SEL, PAGE}, {2'd1, 1'b1});
        check("tp_dead", nHEX, 48'hFFFF_FFFF_A106);

        BLANK_LZ = 1'b0;
        do_reset();
        AUTO = 1'b1;
        for (int k = 0; k < 8; k++) begin
            steps(TD - 1);
            check("tick_wait", {CH_SEL, PAGE}, k);
            step();
            check("tick_adv", {CH_SEL, PAGE}, (k + 1) % 8);
        end
        check("tick_wrap", {CH_SEL, PAGE}, 0);
        steps(TD - 1);
        pulse();
        check("tick_coinc", {CH_SEL, PAGE}, 1);
        steps(TD - 1);
        check("tick_restart", {CH_SEL, PAGE}, 1);
        step();
        check("tick_next", {CH_SEL, PAGE}, 2);

        AUTO = 1'b0;
        do_reset();
        ch[0] = 32'h1;
        steps(2);
        check("hold_pre", nHEX[7:0], 8'hF9);
        HOLD = 1'b1;
        step();
        ch[0] = 32'h2;
        steps(3);
        check("hold_frozen", nHEX[7:0], 8'hF9);
        ch[0] = 32'h1234_5678;
        pulse();
        step();
        ch[0] = 32'h9ABC_DEF0;
        steps(4);
        check("hold_adv_load", nHEX, 48'hFFFF_FFFF_F924);

        AUTO = 1'b1;
        steps(5);
        do_reset();
        HOLD = 1'b0;
        AUTO = 1'b0;
        steps(2);

        for (int c = 0; c < 1500; c++) begin
            NEXT_PAGE = ($urandom % 8) == 0;
            if ($urandom % 40 == 0) AUTO = ~AUTO;
            if ($urandom % 50 == 0) HOLD = ~HOLD;
            if ($urandom % 60 == 0) BLANK_LZ = ~BLANK_LZ;
            if ($urandom % 3 == 0) ch[$urandom % NCH] = $urandom >> ($urandom % 32);
            if ($urandom % 400 == 0) do_reset();
            step();
        end
        NEXT_PAGE = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
